// File: rtl/mem_read_arbiter.sv
// Two-requester AXI4-Lite read arbiter: instruction fetch and load path share one memory read port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; by default the LSU wins simultaneous requests.
module mem_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t                state_q;
  logic                  gnt_q;
  logic [ADDR_WIDTH-1:0] m_araddr_q;
  logic                  m_arvalid_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  last_q;
`endif

  logic win_lsu_s;
  logic any_req_s;
  logic grant_ok_s;

  // Arbitration winner among the current requesters
  always_comb begin
    win_lsu_s = 1'b0;
    if (ifu_arvalid && lsu_arvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_lsu_s = ~last_q;
`else
      win_lsu_s = 1'b1;
`endif
    end else begin
      win_lsu_s = lsu_arvalid;
    end
  end

  // A grant issued in a reset cycle would be lost, so arready is held low then
  assign grant_ok_s  = (state_q == IDLE) && !reset;
  assign any_req_s   = ifu_arvalid | lsu_arvalid;
  assign ifu_arready = grant_ok_s && ifu_arvalid && !win_lsu_s;
  assign lsu_arready = grant_ok_s && lsu_arvalid && win_lsu_s;
  assign m_araddr    = m_araddr_q;
  assign m_arvalid   = m_arvalid_q;

  // Read-data routing to the granted requester; zero outside the R state
  always_comb begin
    ifu_rvalid = 1'b0;
    ifu_rdata  = {DATA_WIDTH{1'b0}};
    ifu_rresp  = 2'b00;
    lsu_rvalid = 1'b0;
    lsu_rdata  = {DATA_WIDTH{1'b0}};
    lsu_rresp  = 2'b00;
    m_rready   = 1'b0;
    if (state_q == R) begin
      if (gnt_q) begin
        lsu_rvalid = m_rvalid;
        lsu_rdata  = m_rdata;
        lsu_rresp  = m_rresp;
        m_rready   = lsu_rready;
      end else begin
        ifu_rvalid = m_rvalid;
        ifu_rdata  = m_rdata;
        ifu_rresp  = m_rresp;
        m_rready   = ifu_rready;
      end
    end else begin
      m_rready = 1'b0;
    end
  end

  // Transaction FSM: grant, forward one address, wait for the single data beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      m_araddr_q  <= {ADDR_WIDTH{1'b0}};
      m_arvalid_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            gnt_q       <= win_lsu_s;
            m_araddr_q  <= win_lsu_s ? lsu_araddr : ifu_araddr;
            m_arvalid_q <= 1'b1;
            state_q     <= AR;
          end
        end
        AR: begin
          if (m_arready) begin
            m_arvalid_q <= 1'b0;
            state_q     <= R;
          end
        end
        R: begin
          if (m_rvalid && m_rready) begin
            state_q <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= gnt_q;
`endif
          end
        end
        default: begin
          m_arvalid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios plus random traffic, checked by a scoreboard monitor.
module tb_mem_read_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ifu_araddr, lsu_araddr, ifu_rdata, lsu_rdata, m_araddr, m_rdata;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [1:0]  ifu_rresp, lsu_rresp, m_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  logic [31:0] req_addr [2];
  logic        req_valid [2];
  logic        req_rready [2];
  int          mode [2];
  int          budget [2];

  int ar_stall_cur = 0, r_lat_cur = 0;
  bit mem_rand = 1'b0;

  int checks = 0, errors = 0;
  int mphase = 0;
  bit last_m = 1'b1, cur_gnt = 1'b0;
  logic [31:0] cur_addr = 32'h0;
  logic [31:0] exp_q0[$], exp_q1[$];
  bit gnt_log[$];
  int done [2] = '{0, 0};
  int ar_wait = 0, r_wait = 0, last_ar_wait = 0, last_r_wait = 0;
  logic [1:0] last_resp [2];

  assign ifu_araddr  = req_addr[0];
  assign ifu_arvalid = req_valid[0];
  assign ifu_rready  = req_rready[0];
  assign lsu_araddr  = req_addr[1];
  assign lsu_arvalid = req_valid[1];
  assign lsu_rready  = req_rready[1];

  mem_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  // Memory contents and response codes are pure functions of the address
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h8000_0013;
  endfunction
  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return a[5:4];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester: holds arvalid/araddr until accepted; may issue more in auto modes
  task automatic run_req(input int id);
    bit hs;
    forever begin
      @(negedge clk);
      hs = (id == 0) ? (ifu_arvalid && ifu_arready) : (lsu_arvalid && lsu_arready);
      @(posedge clk);
      #1;
      if (hs) req_valid[id] = 1'b0;
      if (!req_valid[id] && budget[id] > 0 &&
          (mode[id] == 1 || (mode[id] == 2 && $urandom_range(0, 2) == 0))) begin
        req_addr[id]  = 32'h8000_0000 | (id == 1 ? 32'h0000_1000 : 32'h0) | ($urandom & 32'h0000_0FFC);
        req_valid[id] = 1'b1;
        budget[id]--;
      end
      if (mode[id] == 2) req_rready[id] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    req_addr[0] = 32'h0; req_addr[1] = 32'h0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    req_rready[0] = 1'b1; req_rready[1] = 1'b1;
    mode[0] = 0; mode[1] = 0; budget[0] = 0; budget[1] = 0;
  end
  initial run_req(0);
  initial run_req(1);

  // Memory slave: arready after a configurable stall, one data beat after a configurable latency
  initial begin
    int phase, cnt;
    bit s_rst, s_arv, s_arr, s_rhs;
    logic [31:0] s_addr, lat_addr;
    phase = 0; cnt = 0; lat_addr = 32'h0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    forever begin
      @(negedge clk);
      s_rst = reset; s_arv = m_arvalid; s_arr = m_arready; s_addr = m_araddr;
      s_rhs = m_rvalid && m_rready;
      @(posedge clk);
      #1;
      if (s_rst) begin
        phase = 0; cnt = 0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
      end else begin
        case (phase)
          0: begin
            if (s_arv && s_arr) begin
              m_arready = 1'b0; lat_addr = s_addr; cnt = 0; phase = 1;
            end else begin
              if (s_arv) cnt++;
              m_arready = (cnt >= ar_stall_cur);
            end
          end
          1: cnt++;
          default: begin
            if (s_rhs) begin
              m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00; phase = 0; cnt = 0;
              if (mem_rand) begin
                ar_stall_cur = $urandom_range(0, 3);
                r_lat_cur = $urandom_range(0, 3);
              end
              m_arready = (ar_stall_cur == 0);
            end
          end
        endcase
        if (phase == 1 && cnt >= r_lat_cur) begin
          m_rvalid = 1'b1; m_rdata = mem_data(lat_addr); m_rresp = mem_resp(lat_addr); phase = 2;
        end
      end
    end
  end

  // Monitor/scoreboard: abstract transaction model (idle -> address -> data)
  initial begin
    bit w, w_valid;
    logic [31:0] a, act_d;
    logic [1:0] act_r;
    forever begin
      @(negedge clk);
      if (reset) begin
        mphase = 0; last_m = 1'b1;
        exp_q0.delete(); exp_q1.delete();
      end else begin
        w_valid = ifu_arvalid || lsu_arvalid;
        if (ifu_arvalid && lsu_arvalid) w = RR_EN ? ~last_m : 1'b1;
        else w = lsu_arvalid;
        if (mphase != 0) begin
          chk("arready_busy", 32'({ifu_arready, lsu_arready}), 32'd0);
        end else begin
          chk("ifu_arready", 32'(ifu_arready), 32'(w_valid && !w));
          chk("lsu_arready", 32'(lsu_arready), 32'(w_valid && w));
        end
        chk("m_arvalid", 32'(m_arvalid), 32'(mphase == 1));
        if (mphase == 1) chk("m_araddr", m_araddr, cur_addr);
        chk("ifu_rvalid", 32'(ifu_rvalid), 32'(mphase == 2 && !cur_gnt && m_rvalid));
        chk("lsu_rvalid", 32'(lsu_rvalid), 32'(mphase == 2 && cur_gnt && m_rvalid));
        chk("m_rready", 32'(m_rready), 32'(mphase == 2 && (cur_gnt ? lsu_rready : ifu_rready)));
        if (mphase != 2)
          chk("idle_rdata", 32'(|{ifu_rdata, lsu_rdata, ifu_rresp, lsu_rresp}), 32'd0);
        if (mphase == 1) begin
          if (m_arvalid && !m_arready) ar_wait++;
          if (m_arvalid && m_arready) begin
            last_ar_wait = ar_wait; r_wait = 0; mphase = 2;
          end
        end else if (mphase == 2) begin
          if (m_rvalid && !m_rready) r_wait++;
          if (m_rvalid && m_rready) begin
            act_d = cur_gnt ? lsu_rdata : ifu_rdata;
            act_r = cur_gnt ? lsu_rresp : ifu_rresp;
            if ((cur_gnt ? exp_q1.size() : exp_q0.size()) == 0) begin
              chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
              a = cur_gnt ? exp_q1.pop_front() : exp_q0.pop_front();
              chk(cur_gnt ? "lsu_rdata" : "ifu_rdata", act_d, mem_data(a));
              chk(cur_gnt ? "lsu_rresp" : "ifu_rresp", 32'(act_r), 32'(mem_resp(a)));
            end
            last_resp[cur_gnt] = act_r;
            last_r_wait = r_wait; last_m = cur_gnt; done[cur_gnt]++; mphase = 0;
          end
        end else if (w_valid) begin
          cur_gnt = w;
          cur_addr = w ? lsu_araddr : ifu_araddr;
          if (w) exp_q1.push_back(cur_addr);
          else exp_q0.push_back(cur_addr);
          gnt_log.push_back(w);
          ar_wait = 0; mphase = 1;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_m_arvalid"}, 32'(m_arvalid), 32'd0);
    chk({tag, "_m_araddr"}, m_araddr, 32'd0);
    chk({tag, "_m_rready"}, 32'(m_rready), 32'd0);
    chk({tag, "_arready"}, 32'({ifu_arready, lsu_arready}), 32'd0);
    chk({tag, "_rvalid"}, 32'({ifu_rvalid, lsu_rvalid}), 32'd0);
    chk({tag, "_rdata"}, 32'(|{ifu_rdata, lsu_rdata, ifu_rresp, lsu_rresp}), 32'd0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!(budget[0] == 0 && budget[1] == 0 && !req_valid[0] && !req_valid[1] && mphase == 0)
           && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < max_cyc), 32'd1);
  endtask

  task automatic issue(input int id, input logic [31:0] addr);
    @(posedge clk); #1;
    req_addr[id] = addr;
    req_valid[id] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pi, pl, d0, lst, wexp;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_vals("rst");

    // Single IFU fetch, zero-latency memory
    issue(0, 32'h8000_0000);
    @(negedge clk);
    chk("t1_ifu_arready", 32'(ifu_arready), 32'd1);
    chk("t1_lsu_arready", 32'(lsu_arready), 32'd0);
    @(negedge clk);
    chk("t1_m_arvalid", 32'(m_arvalid), 32'd1);
    chk("t1_m_araddr", m_araddr, 32'h8000_0000);
    @(negedge clk);
    chk("t1_ifu_rvalid", 32'(ifu_rvalid), 32'd1);
    chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0013);
    chk("t1_ifu_rresp", 32'(ifu_rresp), 32'd0);
    chk("t1_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
    wait_idle(50);

    // Simultaneous requests right after reset
    do_reset();
    gnt_log.delete();
    @(posedge clk); #1;
    req_addr[0] = 32'h8000_0004; req_valid[0] = 1'b1;
    req_addr[1] = 32'h8000_1000; req_valid[1] = 1'b1;
    wait_idle(100);
    chk("t2_len", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() == 2) begin
      chk("t2_first", 32'(gnt_log[0]), RR_EN ? 32'd0 : 32'd1);
      chk("t2_second", 32'(gnt_log[1]), RR_EN ? 32'd1 : 32'd0);
    end

    // Both requesting continuously for six transactions
    do_reset();
    gnt_log.delete();
    @(negedge clk);
    budget[0] = 3; budget[1] = 3; mode[0] = 1; mode[1] = 1;
    wait_idle(300);
    mode[0] = 0; mode[1] = 0;
    chk("t3_len", 32'(gnt_log.size()), 32'd6);
    pi = 3; pl = 3; lst = 1;
    for (int k = 0; k < 6 && k < gnt_log.size(); k++) begin
      if (pi > 0 && pl > 0) wexp = RR_EN ? (lst == 1 ? 0 : 1) : 1;
      else wexp = (pl > 0) ? 1 : 0;
      if (wexp == 1) pl--;
      else pi--;
      lst = wexp;
      chk("t3_grant_order", 32'(gnt_log[k]), 32'(wexp));
    end

    // Memory address channel stalls for five cycles
    do_reset();
    gnt_log.delete();
    @(negedge clk);
    ar_stall_cur = 5;
    issue(0, 32'h8000_0100);
    issue(1, 32'h8000_1100);
    wait_idle(200);
    chk("t4_ar_wait", 32'(last_ar_wait), 32'd5);
    chk("t4_order", 32'(gnt_log.size() == 2 && gnt_log[0] == 1'b0 && gnt_log[1] == 1'b1), 32'd1);
    @(negedge clk);
    ar_stall_cur = 0;

    // LSU backpressure with SLVERR response
    do_reset();
    req_rready[1] = 1'b0;
    issue(1, 32'h8000_1020);
    n = 0;
    @(negedge clk);
    while (!lsu_rvalid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rvalid_seen", 32'(n < 30), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 req_rready[1] = 1'b1;
    wait_idle(50);
    chk("t5_r_wait", 32'(last_r_wait), 32'd3);
    chk("t5_rresp", 32'(last_resp[1]), 32'd2);

    // Reset while the address phase is pending
    do_reset();
    @(negedge clk);
    ar_stall_cur = 4;
    issue(0, 32'h8000_0040);
    n = 0;
    @(negedge clk);
    while (!m_arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_ar", 32'(m_arvalid), 32'd1);
    do_reset();
    chk_reset_vals("t6");
    ar_stall_cur = 0;
    d0 = done[0];
    issue(0, 32'h8000_0080);
    wait_idle(50);
    chk("t6_after_reset", 32'(done[0] - d0), 32'd1);

    // Random traffic with random stalls, latencies and backpressure
    do_reset();
    @(negedge clk);
    d0 = done[0] + done[1];
    mem_rand = 1'b1;
    budget[0] = 25; budget[1] = 25; mode[0] = 2; mode[1] = 2;
    wait_idle(4000);
    mode[0] = 0; mode[1] = 0;
    chk("t7_completed", 32'(done[0] + done[1] - d0), 32'd50);
    chk("t7_queues_empty", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
